// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   DATA_WIDTH    : payload bits per frame
//   uart_state_e  : frame sequencer state encoding
//   cnt_width()   : bit-timing counter width for a given clocks-per-bit
//   parity_bit()  : parity over one payload byte, optionally inverted for odd
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } uart_state_e;

  // Width of a counter that runs 0 .. clks_per_bit-1; never narrower than 1.
  function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
    if (clks_per_bit <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(clks_per_bit);
    end
  endfunction

  // XOR of the payload; odd=1 inverts it so the frame carries odd parity.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data,
                                      input logic                  odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period counter. Counts 0 .. CLKS_PER_BIT-1 and wraps; tick is high on
// the last cycle of every bit period so the sequencer only ever asks "is this
// the last cycle of the current bit?".
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   clear   : synchronous clear; holds the counter at 0 (used while idle)
//   tick    : high during the final cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(32'd1);

  logic [CNT_W-1:0] cnt_r;
  logic             last_s;

  assign last_s = (cnt_r == LAST_CNT);
  assign tick   = last_s && !clear;

  // Bit-period counter: held at zero while cleared, wraps after the last cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (last_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + ONE_CNT;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
// 8N1 UART transmitter with a one-entry holding register, so the next byte can
// be accepted while the current frame shifts out and frames run back to back.
// Optional build macro UART_TX_PARITY_EN adds a parity bit (parameter
// PARITY_ODD, 0 = even) between the data bits and the stop bit.
// Ports:
//   clock            : system clock, rising edge
//   reset_n          : asynchronous active-low reset
//   has_data_to_send : upstream valid for data_to_send
//   data_to_send     : byte to transmit, captured on the accepting edge
//   ready            : holding register empty; accept = ready && has_data_to_send
//   outgoing_bit     : registered serial line, idles high
//   is_transmitting  : high from the first start-bit cycle to the last stop-bit
//                      cycle on the line
//   done             : one-cycle pulse on the last line cycle of each stop bit
// The serial outputs are registered from the sequencer state, so the line runs
// one cycle behind the sequencer; all bit widths are preserved by that shift.
// -----------------------------------------------------------------------------
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  has_data_to_send,
  input  logic [DATA_WIDTH-1:0] data_to_send,
  output logic                  ready,
  output logic                  outgoing_bit,
  output logic                  is_transmitting,
  output logic                  done
);

  localparam int unsigned   IDX_W    = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);

  uart_state_e             state_r;
  uart_state_e             state_next_s;
  logic                    tick_s;
  logic                    baud_clear_s;
  logic                    accept_s;
  logic                    load_s;
  logic                    hold_full_r;
  logic                    hold_full_next_s;
  logic [DATA_WIDTH-1:0]   hold_data_r;
  logic [DATA_WIDTH-1:0]   shift_r;
  logic [IDX_W-1:0]        bit_idx_r;
  logic                    line_s;
  logic                    is_tx_s;
  logic                    done_s;
  logic                    ready_r;
  logic                    outgoing_bit_r;
  logic                    is_tx_r;
  logic                    done_r;
`ifdef UART_TX_PARITY_EN
  logic                    parity_r;
`endif

  // The counter only runs while a frame is in progress, so every frame
  // starts from a fresh bit period.
  assign baud_clear_s = (state_r == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (baud_clear_s),
    .tick    (tick_s)
  );

  // ready is a register that always equals "holding register empty".
  assign accept_s = ready_r && has_data_to_send;

  // Holding register hands its byte to the shift register whenever the
  // sequencer is about to enter START_BIT.
  always_comb begin
    load_s = 1'b0;
    if (state_r == IDLE) begin
      load_s = hold_full_r;
    end else if (state_r == STOP_BIT) begin
      load_s = hold_full_r && tick_s;
    end else begin
      load_s = 1'b0;
    end
  end

  // A new acceptance wins over a load on the same edge: the new byte lands
  // in the register the load just emptied.
  always_comb begin
    hold_full_next_s = hold_full_r;
    if (accept_s) begin
      hold_full_next_s = 1'b1;
    end else if (load_s) begin
      hold_full_next_s = 1'b0;
    end else begin
      hold_full_next_s = hold_full_r;
    end
  end

  // Holding register occupancy and the registered ready flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_full_r <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      hold_full_r <= hold_full_next_s;
      ready_r     <= !hold_full_next_s;
    end
  end

  // Holding register payload; only written when empty, so it is stable while full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_data_r <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      hold_data_r <= data_to_send;
    end else begin
      hold_data_r <= hold_data_r;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Sequencer next-state: each bit lasts one bit period; STOP_BIT chains
  // directly into START_BIT when a byte is waiting.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (hold_full_r) begin
          state_next_s = START_BIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      START_BIT: begin
        if (tick_s) begin
          state_next_s = DATA_BITS;
        end else begin
          state_next_s = START_BIT;
        end
      end
      DATA_BITS: begin
        if (tick_s && (bit_idx_r == LAST_IDX)) begin
`ifdef UART_TX_PARITY_EN
          state_next_s = PARITY_BIT;
`else
          state_next_s = STOP_BIT;
`endif
        end else begin
          state_next_s = DATA_BITS;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: begin
        if (tick_s) begin
          state_next_s = STOP_BIT;
        end else begin
          state_next_s = PARITY_BIT;
        end
      end
`endif
      STOP_BIT: begin
        if (tick_s && hold_full_r) begin
          state_next_s = START_BIT;
        end else if (tick_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = STOP_BIT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Sequencer outputs: line level for the current bit plus status strobes.
  always_comb begin
    line_s  = 1'b1;
    is_tx_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        line_s  = 1'b1;
        is_tx_s = 1'b0;
        done_s  = 1'b0;
      end
      START_BIT: begin
        line_s  = 1'b0;
        is_tx_s = 1'b1;
        done_s  = 1'b0;
      end
      DATA_BITS: begin
        line_s  = shift_r[0];
        is_tx_s = 1'b1;
        done_s  = 1'b0;
      end
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: begin
        line_s  = parity_r;
        is_tx_s = 1'b1;
        done_s  = 1'b0;
      end
`endif
      STOP_BIT: begin
        line_s  = 1'b1;
        is_tx_s = 1'b1;
        done_s  = tick_s;
      end
      default: begin
        line_s  = 1'b1;
        is_tx_s = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // Shift register and data-bit index for the frame in flight (LSB first).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_r   <= {DATA_WIDTH{1'b0}};
      bit_idx_r <= {IDX_W{1'b0}};
    end else if (load_s) begin
      shift_r   <= hold_data_r;
      bit_idx_r <= {IDX_W{1'b0}};
    end else if ((state_r == DATA_BITS) && tick_s) begin
      shift_r   <= {1'b0, shift_r[DATA_WIDTH-1:1]};
      bit_idx_r <= bit_idx_r + IDX_ONE;
    end else begin
      shift_r   <= shift_r;
      bit_idx_r <= bit_idx_r;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is captured with the byte so it is ready before the data bits end.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_r <= 1'b0;
    end else if (load_s) begin
      parity_r <= parity_bit(hold_data_r, PARITY_ODD);
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  // Output registers; reset drives the line high immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outgoing_bit_r <= 1'b1;
      is_tx_r        <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      outgoing_bit_r <= line_s;
      is_tx_r        <= is_tx_s;
      done_r         <= done_s;
    end
  end

  assign ready           = ready_r;
  assign outgoing_bit    = outgoing_bit_r;
  assign is_transmitting = is_tx_r;
  assign done            = done_r;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
// Bench for uart_tx_buffered. A frame-level model (queue of one held byte,
// one armed byte, and a line position counter within the current frame)
// predicts every output on every cycle; directed sections pin the model with
// literal expectations. A second instance with CLKS_PER_BIT=300 covers a
// counter wider than 8 bits.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

  localparam int C  = 4;
  localparam int C2 = 300;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam int DONE_CYC = 43;
  localparam logic [10:0] A5_FRAME = 11'b10101001010;
`else
  localparam int NBITS = 10;
  localparam int DONE_CYC = 39;
  localparam logic [10:0] A5_FRAME = 11'b01101001010;
`endif
  localparam int FLEN = NBITS * C;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       has_data_to_send = 1'b0;
  logic [7:0] data_to_send = 8'h00;
  logic       ready, outgoing_bit, is_transmitting, done;

  logic       has2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic       ready2, out2, istx2, done2;

  int vectors = 0;
  int errors = 0;
  int done_seen = 0;

  always #5 clock = ~clock;

  uart_tx_buffered #(.CLKS_PER_BIT(C)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .has_data_to_send (has_data_to_send),
    .data_to_send     (data_to_send),
    .ready            (ready),
    .outgoing_bit     (outgoing_bit),
    .is_transmitting  (is_transmitting),
    .done             (done)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(C2)) dut2 (
    .clock            (clock),
    .reset_n          (reset_n),
    .has_data_to_send (has2),
    .data_to_send     (data2),
    .ready            (ready2),
    .outgoing_bit     (out2),
    .is_transmitting  (istx2),
    .done             (done2)
  );

  // Line value of frame bit k for byte b: start, 8 data LSB first, [parity], stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    else if (k == 9) return ^b;
`endif
    else return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    errors++;
    $display("FAIL %s @%0t: wait bound expired", name, $time);
  endtask

  // ---------------- frame-level reference model ----------------
  // m_t: line cycle within the current frame (-1 = line idle).
  // m_armed: a byte has left the holding register but is not yet on the line.
  bit         m_full = 1'b0;
  bit         m_armed = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic [7:0] m_next = 8'h00;
  logic [7:0] m_cur = 8'h00;
  int         m_t = -1;
  int         m_frames = 0;

  initial forever begin
    bit acc, mv;
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      m_full = 1'b0;
      m_armed = 1'b0;
      m_t = -1;
    end else begin
      acc = !m_full && (has_data_to_send === 1'b1);
      // Byte leaves the holding register when the line is free, or one cycle
      // before the line's last stop cycle so the next start follows it directly.
      mv = m_full && ((m_t < 0 && !m_armed) || m_t >= FLEN - 2);
      if (m_armed) begin
        m_cur = m_next;
        m_t = 0;
        m_armed = 1'b0;
      end else if (m_t >= 0) begin
        m_t = (m_t == FLEN - 1) ? -1 : m_t + 1;
      end
      if (m_t == FLEN - 1) m_frames++;
      if (mv) begin
        m_next = m_hold;
        m_armed = 1'b1;
        m_full = 1'b0;
      end
      if (acc) begin
        m_hold = data_to_send;
        m_full = 1'b1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    logic exp_line;
    @(negedge clock);
    exp_line = (m_t >= 0) ? frame_bit(m_cur, m_t / C) : 1'b1;
    chk("ready", ready, !m_full);
    chk("outgoing_bit", outgoing_bit, exp_line);
    chk("is_transmitting", is_transmitting, m_t >= 0);
    chk("done", done, m_t == FLEN - 1);
    if (done === 1'b1) done_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer a byte and hold it until an edge accepts it (returns #1 after that edge).
  task automatic send(input logic [7:0] b);
    int n;
    logic r;
    n = 0;
    has_data_to_send = 1'b1;
    data_to_send = b;
    forever begin
      @(negedge clock);
      r = ready;
      step();
      if (r) break;
      n++;
      if (n > 4 * FLEN) begin
        timeout("send");
        break;
      end
    end
    has_data_to_send = 1'b0;
    data_to_send = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_t >= 0 || m_full || m_armed) begin
      step();
      n++;
      if (n > 8 * FLEN) begin
        timeout("wait_idle");
        return;
      end
    end
  endtask

  task automatic wait_t(input int target);
    int n;
    n = 0;
    while (m_t != target) begin
      step();
      n++;
      if (n > 8 * FLEN) begin
        timeout("wait_t");
        return;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [10:0] a5_tbl;
    int n;
    a5_tbl = A5_FRAME;

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_line", outgoing_bit, 1'b1);
    chk("rst_istx", is_transmitting, 1'b0);
    chk("rst_done", done, 1'b0);
    repeat (2) step();

    // 0xA5: start at acceptance+2, literal line pattern, done on cycle DONE_CYC.
    send(8'hA5);
    step();
    chk("a5_latency_idle", outgoing_bit, 1'b1);
    for (int i = 0; i < FLEN; i++) begin
      step();
      chk("a5_line", outgoing_bit, a5_tbl[i / C]);
      chk("a5_done", done, i == DONE_CYC);
    end
    wait_idle();
    repeat (3) step();

    // Back-to-back 0x00 then 0xFF: no idle cycle between frames.
    send(8'h00);
    send(8'hFF);
    n = 0;
    while (done !== 1'b1 && n < 4 * FLEN) begin
      step();
      n++;
    end
    if (n >= 4 * FLEN) timeout("b2b_done");
    chk("b2b_ready_at_done", ready, 1'b1);
    step();
    chk("b2b_gap_start", outgoing_bit, 1'b0);
    chk("b2b_gap_istx", is_transmitting, 1'b1);
    wait_idle();
    repeat (2) step();

    // 0x3C offered while ready=0 and held until accepted.
    send(8'h11);
    send(8'h22);
    send(8'h3C);
    wait_idle();
    repeat (2) step();

    // Reset in data bit 3 of 0x81, then 0x55 must frame normally.
    send(8'h81);
    wait_t(4 * C + 1);
    chk("pre_reset_line", outgoing_bit, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_line", outgoing_bit, 1'b1);
    chk("async_rst_ready", ready, 1'b1);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_istx", is_transmitting, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    step();
    send(8'h55);
    wait_idle();
    repeat (2) step();

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    wait_t(9 * C + 1);
    chk("parity_07", outgoing_bit, 1'b1);
    wait_idle();
    send(8'h03);
    wait_t(9 * C + 1);
    chk("parity_03", outgoing_bit, 1'b0);
    wait_idle();
`endif

    // Randomized traffic: mixed gaps, back-to-back bursts, random payloads.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, (i % 4 == 0) ? FLEN + 3 : 2)) step();
      send(8'($urandom));
    end
    wait_idle();
    repeat (2) step();

    // Wide counter instance: 0x01 with 300-cycle bits.
    has2 = 1'b1;
    data2 = 8'h01;
    @(negedge clock);
    chk("w_ready", ready2, 1'b1);
    step();
    has2 = 1'b0;
    data2 = 8'hFE;
    step();
    chk("w_latency_idle", out2, 1'b1);
    for (int i = 0; i < NBITS * C2; i++) begin
      logic e;
      step();
      e = (i < 300) ? 1'b0 : (i < 600) ? 1'b1 : (i < 2700) ? 1'b0 : 1'b1;
      chk("w_line", out2, e);
      chk("w_istx", istx2, 1'b1);
      chk("w_done", done2, i == NBITS * C2 - 1);
    end
    step();
    chk("w_idle_line", out2, 1'b1);
    chk("w_idle_istx", istx2, 1'b0);

    chk("done_count", done_seen, m_frames);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
